// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO pair: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up at the end, optional 1-cycle multiply.
module mips_muldiv_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StPrep, StIter, StFix} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, bmag_q, bmag_d;
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fast_q, fast_d, done_q, done_d;

  logic               is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, res_hi, res_lo;
  logic [WIDTH:0]     mul_sum, mul_step, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, fast_a, fast_b, fast_prod;

  // Datapath arithmetic; decode uses the latched op except for the single-cycle product.
  always_comb begin
    is_signed = ~op_q[0];
    is_div    = op_q[1];
    a_neg     = is_signed & a_q[WIDTH-1];
    b_neg     = is_signed & b_q[WIDTH-1];
    a_mag     = a_neg ? -a_q : a_q;
    b_mag     = b_neg ? -b_q : b_q;
    mul_sum   = {1'b0, acc_q} + {1'b0, bmag_q};
    mul_step  = mq_q[0] ? mul_sum : {1'b0, acc_q};
    div_shift = {acc_q, mq_q[WIDTH-1]};
    // Top bit set means borrow: partial remainder is below the divisor.
    div_diff  = div_shift - {1'b0, bmag_q};
    prod      = {acc_q, mq_q};
    fast_a    = op[0] ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
    fast_b    = op[0] ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
    fast_prod = fast_a * fast_b;
  end

  // Final HI/LO value presented during FIX.
  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (!fast_q) begin
      if (!is_div) begin
        if (a_neg ^ b_neg) {res_hi, res_lo} = -prod;
      end else if (b_q == '0) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_lo = (a_neg ^ b_neg) ? -mq_q : mq_q;
        res_hi = a_neg ? -acc_q : acc_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    bmag_d  = bmag_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    cnt_d   = cnt_q;
    fast_d  = fast_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d = op;
          a_d  = a;
          b_d  = b;
          if (FAST_MUL && !op[1]) begin
            {acc_d, mq_d} = fast_prod;
            fast_d        = 1'b1;
            state_d       = StFix;
          end else begin
            fast_d  = 1'b0;
            state_d = StPrep;
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      StPrep: begin
        bmag_d  = b_mag;
        mq_d    = a_mag;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = StIter;
      end
      StIter: begin
        if (is_div) begin
          acc_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          acc_d = mul_step[WIDTH:1];
          mq_d  = {mul_step[0], mq_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bmag_q  <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
      fast_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bmag_q  <= bmag_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
      fast_q  <= fast_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
